// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one instruction, holds it until execute
// completes, then computes the next PC or stops the core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iread,
    output logic [31:0] iaddr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic [1:0]  pc_ctrl,
    input  logic [31:0] immediate,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic        branch_pol,
    input  logic        halt,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_inst_valid;
    logic [31:0] r_retired;
    logic        r_misaligned;

    state_t      w_state_d;
    logic [31:0] w_pc_d;
    logic [31:0] w_inst_d;
    logic        w_valid_d;
    logic [31:0] w_retired_d;
    logic        w_mis_d;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_imm;
    logic [31:0] w_target;
    logic        w_taken;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_imm   = r_pc + immediate;
    assign w_taken    = zero ^ branch_pol;

    always_comb begin
        w_target = w_pc_plus4;
        unique case (pc_ctrl)
            2'd0: w_target = w_pc_plus4;
            2'd1: w_target = w_taken ? w_pc_imm : w_pc_plus4;
            2'd2: w_target = w_pc_imm;
            2'd3: w_target = {alu_result[31:1], 1'b0};
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_inst_d    = r_inst;
        w_valid_d   = r_inst_valid;
        w_retired_d = r_retired;
        w_mis_d     = r_misaligned;
        unique case (r_state)
            S_FETCH: begin
                if (ihit) begin
                    w_inst_d  = iload;
                    w_valid_d = 1'b1;
                    w_state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (exec_done) begin
                    w_retired_d = r_retired + 32'd1;
                    w_valid_d   = 1'b0;
                    // halt takes priority; a misaligned target stops in place
                    if (halt) begin
                        w_state_d = S_HALTED;
                    end else if (w_target[1:0] != 2'b00) begin
                        w_mis_d   = 1'b1;
                        w_state_d = S_HALTED;
                    end else begin
                        w_pc_d    = w_target;
                        w_state_d = S_FETCH;
                    end
                end
            end
            default: begin
                w_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_retired    <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_inst       <= w_inst_d;
            r_inst_valid <= w_valid_d;
            r_retired    <= w_retired_d;
            r_misaligned <= w_mis_d;
        end
    end

    assign iread      = (r_state == S_FETCH);
    assign iaddr      = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign halted     = (r_state == S_HALTED);
    assign misaligned = r_misaligned;
    assign retired    = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed and random instruction streams
// compared against a behavioural model of fetch/retire/halt.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'd0;
    logic        iread;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done = 1'b0;
    logic [1:0]  pc_ctrl = 2'd0;
    logic [31:0] immediate = 32'd0;
    logic [31:0] alu_result = 32'd0;
    logic        zero = 1'b0;
    logic        branch_pol = 1'b0;
    logic        halt = 1'b0;
    logic        halted;
    logic        misaligned;
    logic [31:0] retired;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .iload      (iload),
        .iread      (iread),
        .iaddr      (iaddr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .exec_done  (exec_done),
        .pc_ctrl    (pc_ctrl),
        .immediate  (immediate),
        .alu_result (alu_result),
        .zero       (zero),
        .branch_pol (branch_pol),
        .halt       (halt),
        .halted     (halted),
        .misaligned (misaligned),
        .retired    (retired)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // model: a PC, a retire count, whether an instruction is held, stop flags
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_halted;
    logic        m_mis;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        chk({tag, ".iaddr"}, iaddr, m_pc);
        chk({tag, ".retired"}, retired, m_ret);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
        chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
        chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, m_valid});
        chk({tag, ".iread"}, {31'd0, iread},
            {31'd0, !m_halted && !m_valid});
        if (m_valid) chk({tag, ".inst"}, inst, m_inst);
    endtask

    function automatic logic [31:0] ref_next(input logic [1:0] c,
        input logic [31:0] p, input logic [31:0] imm,
        input logic [31:0] alu, input logic z, input logic pol);
        case (c)
            2'd0:    return p + 32'd4;
            2'd1:    return (z != pol) ? p + imm : p + 32'd4;
            2'd2:    return p + imm;
            default: return alu & 32'hFFFF_FFFE;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // called at posedge+1; reset lands mid-cycle, no clock edge involved
    task automatic do_reset(input string tag);
        ihit  = 1'b1;
        iload = 32'hDEAD_BEEF;
        #2;
        nRST = 1'b0;
        #1;
        m_pc = 32'd0; m_ret = 32'd0; m_inst = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        check_all(tag);
        chk({tag, ".inst"}, inst, 32'd0);
        ihit = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        check_all({tag, ".rel"});
    endtask

    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("fetch_wait.iaddr", iaddr, m_pc);
            chk("fetch_wait.iread", {31'd0, iread}, 32'd1);
        end
        ihit  = 1'b1;
        iload = word;
        tick();
        ihit  = 1'b0;
        iload = $urandom;
        m_inst  = word;
        m_valid = 1'b1;
        check_all("fetch");
    endtask

    task automatic do_exec(input logic [1:0] c, input logic [31:0] imm,
        input logic [31:0] alu, input logic z, input logic pol,
        input logic h, input logic early_halt);
        logic [31:0] nxt;
        pc_ctrl = c; immediate = imm; alu_result = alu;
        zero = z; branch_pol = pol;
        if (early_halt) begin
            halt = 1'b1;
            tick();
            check_all("halt_no_done");
        end
        halt = h;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        halt = 1'b0;
        m_ret   = m_ret + 32'd1;
        m_valid = 1'b0;
        nxt = ref_next(c, m_pc, imm, alu, z, pol);
        if (h) begin
            m_halted = 1'b1;
        end else if (nxt[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_mis    = 1'b1;
        end else begin
            m_pc = nxt;
        end
        check_all("exec");
    endtask

    task automatic frozen(input int n);
        for (int i = 0; i < n; i++) begin
            ihit = i[0];
            exec_done = ~i[0];
            pc_ctrl = 2'd2;
            immediate = 32'h40;
            tick();
            check_all("frozen");
        end
        ihit = 1'b0;
        exec_done = 1'b0;
    endtask

    initial begin
        logic [1:0]  c;
        logic [31:0] imm;
        logic [31:0] alu;
        m_pc = 32'd0; m_ret = 32'd0; m_inst = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        #1;
        check_all("por");
        chk("por.inst", inst, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        do_fetch(3, 32'h0050_0093);
        do_exec(2'd2, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_fetch(0, 32'h1111_0001);
        do_exec(2'd1, 32'hFFFF_FFF8, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br_taken.pc", pc, 32'hF8);
        do_fetch(1, 32'h1111_0002);
        do_exec(2'd2, 32'h8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h1111_0003);
        do_exec(2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_not.pc", pc, 32'h104);

        do_fetch(0, 32'h2222_0001);
        do_exec(2'd2, 32'hFC, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h2222_0002);
        do_exec(2'd3, 32'd0, 32'h0000_1235, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jalr.pc", pc, 32'h1234);
        do_fetch(0, 32'h2222_0003);
        do_exec(2'd2, 32'h200 - 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h2222_0004);
        do_exec(2'd3, 32'd0, 32'h0000_1236, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jalr_mis.pc", pc, 32'h200);
        frozen(10);
        do_reset("rst_halted_mis");

        do_fetch(0, 32'h3333_0001);
        do_exec(2'd3, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h3333_0002);
        dut.r_retired = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        do_exec(2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap.pc", pc, 32'd0);
        chk("wrap.retired", retired, 32'd0);

        do_fetch(2, 32'h4444_0001);
        do_exec(2'd2, 32'h80, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        frozen(10);
        do_reset("rst_halted");

        tick();
        do_reset("rst_fetch");

        for (int n = 0; n < 60; n++) begin
            do_fetch($urandom_range(0, 2), $urandom);
            c   = 2'($urandom_range(0, 3));
            imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) imm = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 5) != 0) alu[1] = 1'b0;
            do_exec(c, imm, alu, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0);
            if (m_halted) begin
                frozen(2);
                do_reset("rand_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ihit  input  1  instruction memory has valid data on iload this cycle.
REQ-005 iload  input  32  instruction word from memory.
REQ-006 iread  output  1  instruction memory read request.
REQ-007 iaddr  output  32  instruction fetch address, equal to pc.
REQ-008 inst  output  32  captured instruction presented to decode.
REQ-009 inst_valid  output  1  inst holds a fetched, unretired instruction.
REQ-010 pc / pc_plus4  output  32 each  current PC and PC+4 (PC+4 feeds reg_wr_src=2 writeback).
REQ-011 exec_done  input  1  single-cycle pulse; the held instruction has completed execute/memory.
REQ-012 pc_ctrl  input  2  0 sequential, 1 branch, 2 JAL, 3 JALR (from decode).
REQ-013 immediate / alu_result  input  32 each  decoded immediate; ALU output (JALR target).
REQ-014 zero, branch_pol  input  1 each  ALU zero flag; decode branch polarity.
REQ-015 halt  input  1  decode halt request.
REQ-016 halted / misaligned  output  1 each  core stopped; stop caused by misaligned target.
REQ-017 retired  output  32  count of retired instructions.

Function
REQ-018 FSM states: FETCH, HOLD, HALTED; reset state FETCH.
REQ-019 FETCH: iread=1, iaddr=pc; on ihit, inst<=iload, inst_valid<=1, next HOLD; without ihit, remain in FETCH with iaddr stable.
REQ-020 exec_done and all next-PC inputs are ignored in FETCH and HALTED.
REQ-021 HOLD: iread=0, inst and inst_valid stable until exec_done.
REQ-022 Next PC on exec_done in HOLD: pc_ctrl=0 -> pc+4; pc_ctrl=1 -> pc+immediate if (zero XOR branch_pol) else pc+4; pc_ctrl=2 -> pc+immediate; pc_ctrl=3 -> alu_result with bit0 forced to 0.
REQ-023 All PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0; no overflow flag.
REQ-024 exec_done in HOLD, no halt, next PC bits[1:0]==0: pc<=next PC, retired<=retired+1, inst_valid<=0, next FETCH.
REQ-025 exec_done in HOLD with next PC bits[1:0]!=0: pc unchanged, misaligned<=1, retired+1, next HALTED.
REQ-026 halt=1 with exec_done in HOLD: halt wins over every pc_ctrl; pc unchanged, retired+1, next HALTED, misaligned stays 0.
REQ-027 halt=1 without exec_done in HOLD: no effect until exec_done.
REQ-028 HALTED: halted=1, iread=0, inst_valid=0, pc/retired frozen; exit only via reset.
REQ-029 pc_plus4 combinational, always pc+4.
REQ-030 retired wraps 32'hFFFF_FFFF -> 0.

Reset
REQ-031 nRST low asynchronously forces: state FETCH, pc=RESET_PC, inst=0, inst_valid=0, retired=0, halted=0, misaligned=0.
REQ-032 Reset mid-fetch (ihit pending) or in HOLD discards the outstanding instruction; first request after release is at RESET_PC.
REQ-033 iread may assert in the first cycle after nRST deasserts.

Verification
REQ-034 Reset release, ihit after 3 cycles with iload=32'h0050_0093 -> iaddr=0 held all 3 cycles; inst=32'h0050_0093, inst_valid=1 next cycle.
REQ-035 HOLD pc=0x100, pc_ctrl=1, immediate=-8, zero=1, branch_pol=0, exec_done -> pc=0xF8, retired+1; same with zero=0 -> pc=0x104.
REQ-036 HOLD pc=0x200, pc_ctrl=3, alu_result=0x0000_1235, exec_done -> pc=0x1234; alu_result=0x1236 -> misaligned=1, halted=1, pc=0x200.
REQ-037 HOLD with halt=1 and pc_ctrl=2, exec_done -> halted=1, pc unchanged, iread=0 for 10 further cycles despite ihit/exec_done toggling.
REQ-038 pc=32'hFFFF_FFFC, pc_ctrl=0, exec_done -> pc=0; retired preset to 32'hFFFF_FFFF -> 0.
REQ-039 nRST asserted mid-cycle during FETCH and HALTED -> outputs at reset values immediately, without a clock edge.
